// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multiport register file.
package regfile_pkg;

  // Sequencer states: CLEAR zeroes the array, RUN serves normal traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_N_RD   = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: after reset, walks every entry once, writing zero,
// then hands the file over to normal operation.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_done
);

  // One bit wider than the address so the terminal count (DEPTH) is
  // representable and the sweep end is seen without wrap-around.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(1 << ADDR_W);

  rf_state_t       state;
  logic [ADDR_W:0] clr_cnt;
  logic [ADDR_W:0] clr_next;

  assign clr_next = clr_cnt + 1'b1;

  // Reset always restarts the sweep from entry 0; the last entry moves us to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_next;
          if (clr_next == DEPTH_CNT) begin
            state <= RUN;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs are gated by reset so the file looks uninitialised the moment
  // reset rises, even before the registered state catches up.
  assign clr_we    = (state == CLEAR) && !reset;
  assign clr_addr  = clr_cnt[ADDR_W-1:0];
  assign init_done = (state == RUN) && !reset;

endmodule

// File: rtl/regfile_multiport.sv
// Decode-stage register file: N_RD combinational read ports, one write port,
// hardware clear after reset, optional hardwired-zero r0 and write bypass.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int N_RD     = RF_N_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [N_RD*ADDR_W-1:0] raddr,
  output logic [N_RD*DATA_W-1:0] rdata,
  output logic                   init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              ext_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem [DEPTH];

  regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_done(run)
  );

  assign init_done = run;

  // External writes only count in RUN, and r0 writes vanish when r0 is hardwired.
  assign ext_we = run && we && !((ZERO_REG != 0) && (waddr == '0));

  // The clear sweep owns the write port until it finishes.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = waddr;
    mem_data = wdata;
    if (clr_we) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = '0;
    end else if (ext_we) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; no reset here because the sequencer does the clearing.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = raddr[i*ADDR_W +: ADDR_W];

    // Per-port read: hidden while not running, then r0, then bypass, then array.
    always_comb begin
      rd = mem[ra];
      if (!run) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && we && (ra == waddr)) begin
        rd = wdata;
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised and directed bench for regfile_multiport: a default instance
// (32x32, 2 ports, r0 zero, bypass) and a small one (8x16, 4 ports, plain).
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        reset;

  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [9:0]  raddr1;
  logic [63:0] rdata1;
  logic        done1;

  logic        we2;
  logic [2:0]  waddr2;
  logic [15:0] wdata2;
  logic [11:0] raddr2;
  logic [63:0] rdata2;
  logic        done2;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining clear cycles and architectural contents.
  int          left1 = 32;
  int          left2 = 8;
  logic [31:0] m1 [32];
  logic [15:0] m2 [8];

  always #5 clk = ~clk;

  regfile_multiport dut1 (
    .clk      (clk),
    .reset    (reset),
    .we       (we1),
    .waddr    (waddr1),
    .wdata    (wdata1),
    .raddr    (raddr1),
    .rdata    (rdata1),
    .init_done(done1)
  );

  regfile_multiport #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .N_RD    (4),
    .ZERO_REG(0),
    .BYPASS  (0)
  ) dut2 (
    .clk      (clk),
    .reset    (reset),
    .we       (we2),
    .waddr    (waddr2),
    .wdata    (wdata2),
    .raddr    (raddr2),
    .rdata    (rdata2),
    .init_done(done2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref1(input logic [4:0] a);
    if (reset || left1 != 0) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (we1 && a == waddr1) return wdata1;
    return m1[a];
  endfunction

  function automatic logic [15:0] ref2(input logic [2:0] a);
    if (reset || left2 != 0) return 16'd0;
    return m2[a];
  endfunction

  // Called at a falling edge with inputs already driven: checks every output
  // against the model, then advances the model across the next rising edge.
  task automatic applyStimulus();
    #1;
    checkOutput("init_done1", {63'd0, done1}, {63'd0, (!reset && left1 == 0)});
    checkOutput("init_done2", {63'd0, done2}, {63'd0, (!reset && left2 == 0)});
    for (int p = 0; p < 2; p++)
      checkOutput($sformatf("rd1_p%0d", p), {32'd0, rdata1[p*32 +: 32]}, {32'd0, ref1(raddr1[p*5 +: 5])});
    for (int p = 0; p < 4; p++)
      checkOutput($sformatf("rd2_p%0d", p), {48'd0, rdata2[p*16 +: 16]}, {48'd0, ref2(raddr2[p*3 +: 3])});
    @(posedge clk);
    if (reset) begin
      left1 = 32;
      left2 = 8;
      foreach (m1[i]) m1[i] = 32'd0;
      foreach (m2[i]) m2[i] = 16'd0;
    end else begin
      if (left1 > 0) left1--;
      else if (we1 && waddr1 != 5'd0) m1[waddr1] = wdata1;
      if (left2 > 0) left2--;
      else if (we2) m2[waddr2] = wdata2;
    end
    @(negedge clk);
  endtask

  task automatic randomCycles(input int n);
    for (int k = 0; k < n; k++) begin
      we1    = 1'($urandom_range(0, 1));
      waddr1 = 5'($urandom());
      wdata1 = $urandom();
      raddr1 = 10'($urandom());
      if ($urandom_range(0, 3) == 0) raddr1[4:0] = waddr1;
      we2    = 1'($urandom_range(0, 1));
      waddr2 = 3'($urandom());
      wdata2 = 16'($urandom());
      raddr2 = 12'($urandom());
      if ($urandom_range(0, 3) == 0) raddr2[2:0] = waddr2;
      applyStimulus();
    end
    we1 = 1'b0;
    we2 = 1'b0;
  endtask

  initial begin
    int low;
    reset  = 1'b1;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; raddr1 = '0;
    we2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
    foreach (m1[i]) m1[i] = 32'd0;
    foreach (m2[i]) m2[i] = 16'd0;
    @(negedge clk);

    // Power-up clear: three reset cycles, then count cycles until init_done.
    repeat (3) applyStimulus();
    reset = 1'b0;
    low = 0;
    while (!done1 && low < 100) begin
      applyStimulus();
      low++;
    end
    checkOutput("init_low_cycles", 64'(low), 64'd32);
    for (int a = 0; a < 32; a++) begin
      raddr1 = {5'(a), 5'(a)};
      raddr2 = {4{3'(a)}};
      #1;
      checkOutput("clr_read1", rdata1, 64'd0);
      checkOutput("clr_read2", rdata2, 64'd0);
      applyStimulus();
    end

    // Write then read back on both ports.
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'hDEADBEEF;
    applyStimulus();
    we1 = 1'b0; raddr1 = {5'd5, 5'd5};
    #1;
    checkOutput("r5_both", rdata1, 64'hDEADBEEF_DEADBEEF);
    applyStimulus();

    // Hardwired r0: write is dropped, r1 unaffected.
    we1 = 1'b1; waddr1 = 5'd1; wdata1 = 32'h11111111;
    applyStimulus();
    waddr1 = 5'd0; wdata1 = 32'h12345678;
    applyStimulus();
    we1 = 1'b0; raddr1 = {5'd1, 5'd0};
    #1;
    checkOutput("r0_zero", {32'd0, rdata1[31:0]}, 64'd0);
    checkOutput("r1_kept", {32'd0, rdata1[63:32]}, 64'h11111111);
    applyStimulus();

    // Same-cycle read/write of r7: bypass vs. old value.
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h1;
    we2 = 1'b1; waddr2 = 3'd7; wdata2 = 16'h1;
    applyStimulus();
    wdata1 = 32'hA5A5A5A5; raddr1 = {5'd7, 5'd7};
    wdata2 = 16'hA5A5;     raddr2 = {4{3'd7}};
    #1;
    checkOutput("bypass_on", {32'd0, rdata1[31:0]}, 64'hA5A5A5A5);
    checkOutput("bypass_off", {48'd0, rdata2[15:0]}, 64'h1);
    applyStimulus();
    we1 = 1'b0; we2 = 1'b0;
    #1;
    checkOutput("bypass_off_next", {48'd0, rdata2[15:0]}, 64'hA5A5);
    applyStimulus();

    // Four ports, mixed addresses, and a writable r0 on the plain instance.
    we2 = 1'b1; waddr2 = 3'd1; wdata2 = 16'h1111; applyStimulus();
    waddr2 = 3'd2; wdata2 = 16'h2222; applyStimulus();
    waddr2 = 3'd7; wdata2 = 16'h7777; applyStimulus();
    waddr2 = 3'd0; wdata2 = 16'hBEEF; applyStimulus();
    we2 = 1'b0; raddr2 = {3'd7, 3'd1, 3'd2, 3'd1};
    #1;
    checkOutput("four_ports", rdata2, 64'h7777_1111_2222_1111);
    applyStimulus();
    raddr2 = {3'd0, 3'd0, 3'd0, 3'd0};
    #1;
    checkOutput("r0_writable", rdata2, 64'hBEEF_BEEF_BEEF_BEEF);
    applyStimulus();

    randomCycles(200);

    // Fill, reset, interrupt the sweep at clr_cnt=10, and poke writes mid-clear.
    for (int a = 1; a < 32; a++) begin
      we1 = 1'b1; waddr1 = 5'(a); wdata1 = $urandom() | 32'h1;
      we2 = 1'b1; waddr2 = 3'(a); wdata2 = 16'($urandom()) | 16'h1;
      applyStimulus();
    end
    we1 = 1'b0; we2 = 1'b0;
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      we1 = (c == 5); waddr1 = 5'd3; wdata1 = 32'hFFFFFFFF;
      we2 = (c == 5); waddr2 = 3'd2; wdata2 = 16'hFFFF;
      applyStimulus();
    end
    we1 = 1'b0; we2 = 1'b0;
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    low = 0;
    while (!done1 && low < 100) begin
      we1 = (low == 20); waddr1 = 5'd4; wdata1 = 32'hCAFEF00D;
      we2 = (low == 5);  waddr2 = 3'd3; wdata2 = 16'hF00D;
      applyStimulus();
      low++;
    end
    we1 = 1'b0; we2 = 1'b0;
    checkOutput("reinit_low_cycles", 64'(low), 64'd32);
    for (int a = 0; a < 32; a++) begin
      raddr1 = {5'(a), 5'(a)};
      raddr2 = {4{3'(a)}};
      #1;
      checkOutput("reclr_read1", rdata1, 64'd0);
      checkOutput("reclr_read2", rdata2, 64'd0);
      applyStimulus();
    end

    randomCycles(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
